calc_entry_ctrl: RTL

Sequencer between the keypad scanner and the calculator ALU. It turns scanner key events (4-bit key code plus key-held flag) into decimal operands and an operator. It launches one ALU operation per request over a start/done handshake and holds the value to display. It owns all entry-state sequencing; the ALU is purely a datapath slave.

---
 rtl/calc_entry_ctrl.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/calc_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : calc_entry_ctrl
//  Purpose  : Entry sequencer between the keypad scanner and the calculator
//             ALU. Converts key events into decimal operands and an operator,
//             launches one ALU operation per request (start/done handshake)
//             and holds the value to display.
//  Ports    : IN_clk, IN_rst_n        clock, synchronous active-low reset
//             IN_value, IN_key        scanner key code and key-held flag
//             OUT_alu_a/b/op/start    ALU operands, op code, launch pulse
//             IN_alu_done/result      ALU completion and result
//             OUT_disp                value to display
//             OUT_state               current sequencer state (debug/LEDs)
//             OUT_err                 sticky ALU-timeout flag
//  Revision : 1.0  initial release
// ============================================================================
module calc_entry_ctrl #(
    parameter int W       = 16,
    parameter int DIGITS  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic         IN_clk,
    input  logic         IN_rst_n,
    input  logic [3:0]   IN_value,
    input  logic         IN_key,
    output logic [W-1:0] OUT_alu_a,
    output logic [W-1:0] OUT_alu_b,
    output logic [2:0]   OUT_alu_op,
    output logic         OUT_alu_start,
    input  logic         IN_alu_done,
    input  logic [W-1:0] IN_alu_result,
    output logic [W-1:0] OUT_disp,
    output logic [2:0]   OUT_state,
    output logic         OUT_err
);

    localparam int c_cnt_w = $clog2(DIGITS + 1);
    localparam int c_tmr_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_RES  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t               r_state;
    logic                 r_key_d;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic [2:0]           r_op;
    logic [2:0]           r_pend_op;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [W-1:0]         r_result;
    logic                 r_next_res;   // 1: EXEC returns to S_RES, 0: to S_OP
    logic [c_tmr_w-1:0]   r_timer;      // completed cycles in S_EXEC
    logic                 r_err;
    logic                 r_start;
    logic [W-1:0]         r_disp;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    state_t               w_state_nxt;
    logic [W-1:0]         w_a_nxt;
    logic [W-1:0]         w_b_nxt;
    logic [2:0]           w_op_nxt;
    logic [2:0]           w_pend_op_nxt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [W-1:0]         w_result_nxt;
    logic                 w_next_res_nxt;
    logic [c_tmr_w-1:0]   w_timer_nxt;
    logic                 w_err_nxt;
    logic                 w_start_nxt;
    logic [W-1:0]         w_disp_nxt;

    // ------------------------------------------------------------------
    // Key decode
    // ------------------------------------------------------------------
    logic                 w_event;
    logic                 w_is_digit;
    logic                 w_is_op;
    logic                 w_is_eq;
    logic [2:0]           w_op_code;
    logic [W-1:0]         w_digit;
    logic                 w_cnt_full;
    logic                 w_done_ok;
    logic                 w_timed_out;

    // One event per press: only the low-to-high transition of the held flag.
    assign w_event    = IN_key & ~r_key_d;
    assign w_is_digit = (IN_value <= 4'd9);
    assign w_is_op    = (IN_value >= 4'd10) && (IN_value <= 4'd14);
    assign w_is_eq    = (IN_value == 4'd15);
    // Codes 10..14 map to 0..4; the low three bits minus two give that
    // mapping directly without carrying the unused upper bit.
    assign w_op_code  = IN_value[2:0] - 3'd2;
    assign w_digit    = W'(IN_value);
    assign w_cnt_full = (r_cnt >= c_cnt_w'(DIGITS));
    // Done is ignored in the start cycle so a stale done from the previous
    // operation cannot complete the new one.
    assign w_done_ok  = IN_alu_done && (r_timer != '0);
    assign w_timed_out = (r_timer == c_tmr_w'(TIMEOUT - 1));

    // X*10 + d using shifts, truncated to W bits.
    function automatic logic [W-1:0] f_acc(input logic [W-1:0] x, input logic [W-1:0] d);
        return (x << 3) + (x << 1) + d;
    endfunction

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_op_nxt       = r_op;
        w_pend_op_nxt  = r_pend_op;
        w_cnt_nxt      = r_cnt;
        w_result_nxt   = r_result;
        w_next_res_nxt = r_next_res;
        w_timer_nxt    = r_timer;
        w_err_nxt      = r_err;
        w_start_nxt    = 1'b0;
        w_disp_nxt     = r_disp;

        unique case (r_state)
            S_A: begin
                if (w_event) begin
                    if (w_is_digit) begin
                        // Starting fresh entry clears a stale timeout flag.
                        w_err_nxt = 1'b0;
                        if (!w_cnt_full) begin
                            w_a_nxt   = f_acc(r_a, w_digit);
                            w_cnt_nxt = r_cnt + c_cnt_w'(1);
                        end
                    end else if (w_is_op) begin
                        w_op_nxt    = w_op_code;
                        w_state_nxt = S_OP;
                    end
                end
            end

            S_OP: begin
                if (w_event) begin
                    if (w_is_digit) begin
                        w_b_nxt     = w_digit;
                        w_cnt_nxt   = c_cnt_w'(1);
                        w_state_nxt = S_B;
                    end else if (w_is_op) begin
                        w_op_nxt = w_op_code;
                    end
                end
            end

            S_B: begin
                if (w_event) begin
                    if (w_is_digit) begin
                        if (!w_cnt_full) begin
                            w_b_nxt   = f_acc(r_b, w_digit);
                            w_cnt_nxt = r_cnt + c_cnt_w'(1);
                        end
                    end else if (w_is_eq) begin
                        w_next_res_nxt = 1'b1;
                        w_state_nxt    = S_EXEC;
                    end else if (w_is_op) begin
                        // Chained operator: current op runs first, the new
                        // one is applied to its result afterwards.
                        w_pend_op_nxt  = w_op_code;
                        w_next_res_nxt = 1'b0;
                        w_state_nxt    = S_EXEC;
                    end
                end
            end

            S_EXEC: begin
                w_timer_nxt = r_timer + c_tmr_w'(1);
                if (w_done_ok) begin
                    w_result_nxt = IN_alu_result;
                    if (r_next_res) begin
                        w_state_nxt = S_RES;
                    end else begin
                        w_a_nxt     = IN_alu_result;
                        w_op_nxt    = r_pend_op;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_OP;
                    end
                end else if (w_timed_out) begin
                    w_err_nxt   = 1'b1;
                    w_a_nxt     = '0;
                    w_b_nxt     = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_A;
                end
            end

            S_RES: begin
                if (w_event) begin
                    if (w_is_digit) begin
                        w_a_nxt     = w_digit;
                        w_cnt_nxt   = c_cnt_w'(1);
                        w_err_nxt   = 1'b0;
                        w_state_nxt = S_A;
                    end else if (w_is_op) begin
                        w_a_nxt     = r_result;
                        w_op_nxt    = w_op_code;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_OP;
                    end else begin
                        // Repeat equals: previous result becomes A, B and
                        // op are reused.
                        w_a_nxt        = r_result;
                        w_next_res_nxt = 1'b1;
                        w_state_nxt    = S_EXEC;
                    end
                end
            end

            default: begin
                w_state_nxt = S_A;
            end
        endcase

        // Every entry into S_EXEC launches the ALU exactly once and restarts
        // the wait counter.
        if ((w_state_nxt == S_EXEC) && (r_state != S_EXEC)) begin
            w_start_nxt = 1'b1;
            w_timer_nxt = '0;
        end

        // Display follows the state being entered so it is valid one cycle
        // after the key event; during S_EXEC it keeps showing the old value.
        unique case (w_state_nxt)
            S_A, S_OP: w_disp_nxt = w_a_nxt;
            S_B:       w_disp_nxt = w_b_nxt;
            S_RES:     w_disp_nxt = w_result_nxt;
            default:   w_disp_nxt = r_disp;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge IN_clk) begin
        if (!IN_rst_n) begin
            r_state    <= S_A;
            r_key_d    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_pend_op  <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_next_res <= 1'b0;
            r_timer    <= '0;
            r_err      <= 1'b0;
            r_start    <= 1'b0;
            r_disp     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_key_d    <= IN_key;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_op       <= w_op_nxt;
            r_pend_op  <= w_pend_op_nxt;
            r_cnt      <= w_cnt_nxt;
            r_result   <= w_result_nxt;
            r_next_res <= w_next_res_nxt;
            r_timer    <= w_timer_nxt;
            r_err      <= w_err_nxt;
            r_start    <= w_start_nxt;
            r_disp     <= w_disp_nxt;
        end
    end

    // A, B and op are never written while in S_EXEC, so the operands stay
    // stable from the start pulse until done.
    assign OUT_alu_a     = r_a;
    assign OUT_alu_b     = r_b;
    assign OUT_alu_op    = r_op;
    assign OUT_alu_start = r_start;
    assign OUT_disp      = r_disp;
    assign OUT_state     = r_state;
    assign OUT_err       = r_err;

endmodule
`default_nettype wire
